// File: rtl/fft_ctrl_seq.sv
// Control sequencer between the MCU register bank and the FFT / tone-detector datapath:
// frames MCU samples into the FFT, streams bins to the tone detector and reports the tone.
module fft_ctrl_seq #(
  parameter int DATA_W  = 16,
  parameter int FFT_LEN = 1024,
  parameter int RST_CYC = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] mcu_cmd,
  input  logic              sample_wr,
  input  logic [DATA_W-1:0] sample_in,
  output logic [DATA_W-1:0] i_sample,
  output logic              i_ce,
  input  logic [DATA_W-1:0] o_result,
  input  logic              o_sync,
  output logic [DATA_W-1:0] td_bin,
  output logic              td_valid,
  output logic              TDenable,
  input  logic              done,
  input  logic [DATA_W-1:0] Tone,
  output logic [DATA_W-1:0] asic_status,
  output logic [DATA_W-1:0] results,
  output logic              FFT_rst,
  output logic              TD_rst
);

  localparam int CW = $clog2(FFT_LEN) + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam int FW = DATA_W - 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    LOAD   = 3'd2,
    DRAIN  = 3'd3,
    DETECT = 3'd4,
    REPORT = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            start_prev;
  logic [RW-1:0]   rst_cnt;
  logic [CW-1:0]   smp_cnt;
  logic [CW-1:0]   bin_cnt;
  logic [WW-1:0]   wd_cnt;
  logic            synced;
  logic            mode;
  logic            res_valid;
  logic            overrun;
  logic            timeout;
  logic [FW-1:0]   frame_cnt;

  logic            abort;
  logic            start_edge;
  logic            accept;
  logic            bin_hit;
  logic            wd_expire;
  logic            mode_nx;
  logic            rv_nx;
  logic            ovr_nx;
  logic            tmo_nx;
  logic [FW-1:0]   fc_nx;
  logic            cmd_unused;

  assign cmd_unused = ^mcu_cmd[DATA_W-1:3];

  // Next-state and next status-field computation
  always_comb begin
    abort      = mcu_cmd[1];
    start_edge = mcu_cmd[0] & ~start_prev;
    accept     = (state == LOAD) & sample_wr & ~abort;
    bin_hit    = (state == DRAIN) & i_ce & (synced | o_sync);
    wd_expire  = (wd_cnt == WW'(TIMEOUT - 1));
    state_nx   = state;
    mode_nx    = mode;
    rv_nx      = res_valid;
    ovr_nx     = overrun;
    tmo_nx     = timeout;
    fc_nx      = frame_cnt;
    case (state)
      IDLE: begin
        if (start_edge && !abort) begin
          state_nx = ARM;
          mode_nx  = mcu_cmd[2];
          rv_nx    = 1'b0;
          ovr_nx   = 1'b0;
          tmo_nx   = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end
      ARM: begin
        if (rst_cnt == RW'(RST_CYC - 1)) state_nx = LOAD;
        else                             state_nx = ARM;
      end
      LOAD: begin
        if (accept && (smp_cnt == CW'(FFT_LEN - 1))) state_nx = DRAIN;
        else                                         state_nx = LOAD;
      end
      DRAIN: begin
        if (bin_hit) begin
          if (bin_cnt == CW'(FFT_LEN - 1)) state_nx = DETECT;
          else                             state_nx = DRAIN;
        end else if (!synced && wd_expire) begin
          tmo_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = DRAIN;
        end
      end
      DETECT: begin
        if (done) begin
          state_nx = REPORT;
        end else if (wd_expire) begin
          tmo_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = DETECT;
        end
      end
      REPORT: begin
        rv_nx = 1'b1;
        fc_nx = frame_cnt + FW'(1);
        if (mode) state_nx = ARM;
        else      state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (sample_wr && (state != LOAD)) ovr_nx = 1'b1;
    else                              ovr_nx = ovr_nx;
    if (abort) state_nx = IDLE;
    else       state_nx = state_nx;
  end

  // State, counters, status fields and all registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      start_prev  <= 1'b0;
      rst_cnt     <= {RW{1'b0}};
      smp_cnt     <= {CW{1'b0}};
      bin_cnt     <= {CW{1'b0}};
      wd_cnt      <= {WW{1'b0}};
      synced      <= 1'b0;
      mode        <= 1'b0;
      res_valid   <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
      frame_cnt   <= {FW{1'b0}};
      i_sample    <= {DATA_W{1'b0}};
      i_ce        <= 1'b0;
      td_bin      <= {DATA_W{1'b0}};
      td_valid    <= 1'b0;
      TDenable    <= 1'b0;
      results     <= {DATA_W{1'b0}};
      asic_status <= {DATA_W{1'b0}};
      FFT_rst     <= 1'b1;
      TD_rst      <= 1'b1;
    end else begin
      state      <= state_nx;
      start_prev <= mcu_cmd[0];
      mode       <= mode_nx;
      res_valid  <= rv_nx;
      overrun    <= ovr_nx;
      timeout    <= tmo_nx;
      frame_cnt  <= fc_nx;
      rst_cnt    <= (state == ARM) ? rst_cnt + RW'(1) : {RW{1'b0}};
      smp_cnt    <= (state == LOAD) ? (accept ? smp_cnt + CW'(1) : smp_cnt) : {CW{1'b0}};
      bin_cnt    <= (state == DRAIN) ? (bin_hit ? bin_cnt + CW'(1) : bin_cnt) : {CW{1'b0}};
      synced     <= (state == DRAIN) & (synced | (o_sync & i_ce));
      // Watchdog restarts on every state change; it only runs while waiting on o_sync or done
      if (state_nx != state)
        wd_cnt <= {WW{1'b0}};
      else if (((state == DRAIN) && !synced) || (state == DETECT))
        wd_cnt <= wd_cnt + WW'(1);
      else
        wd_cnt <= {WW{1'b0}};
      i_sample    <= accept ? sample_in : {DATA_W{1'b0}};
      i_ce        <= accept | ((state == DRAIN) && (state_nx == DRAIN));
      td_valid    <= bin_hit & ~abort;
      td_bin      <= (bin_hit && !abort) ? o_result : td_bin;
      TDenable    <= (state_nx == DRAIN) || (state_nx == DETECT);
      FFT_rst     <= (state_nx == IDLE) || (state_nx == ARM);
      TD_rst      <= (state_nx == IDLE) || (state_nx == ARM);
      results     <= (state == REPORT) ? Tone : results;
      asic_status <= {fc_nx, mode_nx, tmo_nx, ovr_nx, rv_nx, (state_nx != IDLE), state_nx};
    end
  end

endmodule

// File: doc/fft_ctrl_seq.md
# fft_ctrl_seq

Parametrised control sequencer that sits between the I2C register bank and the FFT / tone-detector datapath. It collects MCU-written samples into an FFT frame of configurable length and flushes the frame through the FFT core. It then streams the FFT bins to the tone detector, latches the detected tone into the results register, and reports status. It supports single-shot and continuous modes, core reset sequencing, overrun detection and watchdog timeouts.

## Interface
Parameters:
- DATA_W, 16: sample, result, tone and register width.
- FFT_LEN, 1024: samples per frame. Must be a power of two, ≥ 4.
- RST_CYC, 4: cycles the cores are held in reset before each frame. Must be ≥ 1.
- TIMEOUT, 65535: watchdog limit in cycles for the wait on `o_sync` and the wait on `done`.

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  synchronous, active-low reset.
- mcu_cmd  in  DATA_W  MCU status register, {msb,lsb}. Bit0 start, bit1 abort, bit2 mode (0 single, 1 continuous).
- sample_wr  in  1  one-cycle strobe; the MCU completed a sample-register write.
- sample_in  in  DATA_W  sample register contents, {msb,lsb}.
- i_sample  out  DATA_W  sample to the FFT.
- i_ce  out  1  FFT clock enable.
- o_result  in  DATA_W  FFT bin output.
- o_sync  in  1  FFT first-bin marker, qualified by `i_ce`.
- td_bin  out  DATA_W  bin to the tone detector.
- td_valid  out  1  `td_bin` valid.
- TDenable  out  1  tone detector enable.
- done  in  1  tone detector finished.
- Tone  in  DATA_W  detected tone index.
- asic_status  out  DATA_W  status register.
- results  out  DATA_W  results register.
- FFT_rst  out  1  active-high FFT core reset.
- TD_rst  out  1  active-high tone detector reset.

## Operation
- States:
  - IDLE: waits for a start.
  - ARM: holds the cores in reset.
  - LOAD: accepts frame samples.
  - DRAIN: flushes the FFT and streams bins.
  - DETECT: waits for the tone detector.
  - REPORT: latches the result.
- Encoding is 0–5 in that order, and is exposed in `asic_status[2:0]`.
- Start is the rising edge of `mcu_cmd[0]`, taken from a registered previous value. Start is ignored outside IDLE.
- Abort is level-sensitive: while `mcu_cmd[1]`=1, the next state is IDLE from any state. Abort wins over start in the same cycle.
- IDLE: `FFT_rst`=`TD_rst`=1. On start, clear the overrun, timeout and result_valid bits, latch mode, and go to ARM.
- ARM: reset stays asserted for exactly RST_CYC cycles, then go to LOAD. Both resets deassert on the first LOAD cycle.
- LOAD: each `sample_wr` registers `sample_in` into `i_sample` and pulses `i_ce` the following cycle. After the FFT_LEN-th accepted sample, go to DRAIN.
- DRAIN:
  - `i_ce`=1 every cycle with `i_sample`=0 (zero flush). `TDenable`=1.
  - Before `o_sync`: the watchdog counts. Reaching TIMEOUT sets the timeout bit and goes to IDLE.
  - From the `o_sync` cycle: count FFT_LEN bins. Each bin produces `td_bin`<=`o_result` and `td_valid`<=1, registered.
  - After the FFT_LEN-th bin, go to DETECT.
- DETECT: `TDenable`=1 and `i_ce`=0. The watchdog restarts from 0.
  - `done`=1: go to REPORT.
  - TIMEOUT reached: set the timeout bit and go to IDLE.
- REPORT (1 cycle):
  - `results`<=`Tone`, result_valid<=1, frame_cnt+=1 (wraps).
  - Next state: ARM if mode=1 and no abort, else IDLE.
- Overrun: `sample_wr` outside LOAD sets the sticky overrun bit and the sample is dropped. The bit is cleared only by the next start.
- `asic_status` layout:
  - [2:0] state.
  - [3] busy (state≠IDLE).
  - [4] result_valid.
  - [5] overrun.
  - [6] timeout.
  - [7] latched mode.
  - [DATA_W-1:8] frame_cnt.
- Counters are $clog2(FFT_LEN)+1 bits for samples and bins, and $clog2(TIMEOUT+1) bits for the watchdog.

## Timing
- Reset values: state IDLE; `i_sample`=0, `i_ce`=0, `td_bin`=0, `td_valid`=0, `TDenable`=0, `results`=0, `asic_status`=0, `FFT_rst`=1, `TD_rst`=1.
- Reset asserted mid-frame behaves identically to power-on reset: all counters and frame_cnt are cleared.
- All outputs are registered.
- `sample_wr`→`i_ce`: 1 cycle latency.
- `o_result`→`td_valid`: 1 cycle latency.
- `done`→`results` update: 2 cycles (DETECT→REPORT, then the register write).
- Start edge→first LOAD cycle: 1+RST_CYC cycles.
- `sample_wr` on the same cycle that LOAD is entered is accepted.
- `sample_wr` on the cycle after the last sample (state DRAIN) counts as an overrun.
- Abort in DRAIN: `i_ce`, `td_valid` and `TDenable` are 0 on the next cycle, and both resets are 1.
- A `td_valid` pulse is never issued for a bin past FFT_LEN.
- `results` is held until the next REPORT. A start does not clear `results`, only result_valid.

## Test plan
- Single shot, FFT_LEN=8, RST_CYC=2:
  - Stimulus: start, 8 `sample_wr` strobes with values 1..8, FFT model asserts `o_sync` 5 cycles into DRAIN, `done`=1 with `Tone`=0x0003.
  - Required: `results`=0x0003; `asic_status`=0x0110 (IDLE, result_valid, frame_cnt=1); exactly 8 `td_valid` pulses.
- Continuous mode:
  - Stimulus: `mcu_cmd`=0x0005, run 3 frames, then abort.
  - Required: frame_cnt=3; `FFT_rst` high for exactly 2 cycles between frames; state=0 within 1 cycle of abort.
- Overrun: `sample_wr` during ARM and DRAIN.
  - Required: `asic_status[5]`=1, FFT sees only the 8 LOAD samples.
  - Follow-up: next start clears bit 5.
- Timeout:
  - Stimulus: TIMEOUT=20, `o_sync` never asserted.
  - Required: IDLE 20 cycles after DRAIN entry; `asic_status[6]`=1; `results` unchanged.
  - Repeat with `done` withheld in DETECT; same required response.
- Simultaneous start and abort rising in the same cycle from IDLE:
  - Required: stays in IDLE, status bits not cleared.
  - Also required: a start held high for 10 cycles triggers exactly one frame.
- Reset mid-LOAD after 3 samples:
  - Required: all outputs at their reset values on the next cycle.
  - Follow-up: a new start requires a full 8 samples.
